// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side master for sync_fifo. Pulls words through
// fifo_rd_en/fifo_dout/fifo_empty and re-presents them as a valid/ready stream
// with burst framing (m_last on every BURST_LEN-th word).
// A 2-entry buffer absorbs the one-cycle FIFO read latency, so a word that is
// already in flight always has a slot to land in, even under backpressure.
// Optional feature macro: FIFO_RD_CNT_EN enables the delivered-word counter.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [CNT_WIDTH-1:0]  word_count
);

   localparam int            BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);

   // entry 0 is the head and drives m_data directly
   logic [1:0][DATA_WIDTH-1:0] r_buf;
   logic [1:0]                 r_occ;
   logic                       r_inflight;
   logic [BW-1:0]              r_bcnt;

   logic                       w_pop;
   logic [2:0]                 w_level;
   logic [1:0]                 w_occ_ap;

   assign w_pop    = (r_occ != 2'd0) && m_ready;
   // slots committed after this cycle: held words + word landing - word leaving
   assign w_level  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_occ_ap = r_occ - {1'b0, w_pop};

   assign fifo_rd_en = !reset && enable && !fifo_empty && (w_level < 3'd2);

   assign m_valid = (r_occ != 2'd0);
   assign m_data  = r_buf[0];
   assign m_last  = m_valid && (r_bcnt == LAST_IDX);

   // buffer: shift on pop, then land the in-flight word in the first free slot
   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf      <= '0;
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= fifo_rd_en;
         if (w_pop)
            r_buf[0] <= r_buf[1];
         if (r_inflight) begin
            if (w_occ_ap == 2'd0)
               r_buf[0] <= fifo_dout;
            else
               r_buf[1] <= fifo_dout;
         end
         r_occ <= w_occ_ap + {1'b0, r_inflight};
      end
   end

   // burst position of the head word; wraps after the last word is popped
   always_ff @(posedge clk) begin
      if (reset)
         r_bcnt <= '0;
      else if (w_pop)
         r_bcnt <= (r_bcnt == LAST_IDX) ? '0 : r_bcnt + 1'b1;
   end

`ifdef FIFO_RD_CNT_EN
   logic [CNT_WIDTH-1:0] r_wcnt;

   // delivered-word counter, free-running modulo 2^CNT_WIDTH
   always_ff @(posedge clk) begin
      if (reset)
         r_wcnt <= '0;
      else if (w_pop)
         r_wcnt <= r_wcnt + 1'b1;
   end

   assign word_count = r_wcnt;
`else
   assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a behavioural sync_fifo model feeds the DUT,
// stimulus pushes expected {last,data} into a scoreboard queue, and a monitor
// pops and compares on every accepted output word.
module tb_fifo_stream_reader;

   logic       clk = 1'b0;
   logic       reset, enable, fifo_empty, fifo_rd_en, m_valid, m_ready, m_last;
   logic [7:0] fifo_dout, m_data;
   logic [15:0] word_count;

   fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   logic [7:0] fq[$];      // FIFO contents
   logic [7:0] pend_q[$];  // words written this cycle, visible next edge
   logic [8:0] exp_q[$];   // scoreboard {last,data}
   int  pushed = 0, pops = 0, reads = 0, rd_viol = 0, cyc = 0;
   int  first_n = -1, first_v = -1, first_pop = -1, last_pop = -1;
   logic rd_take = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // sync_fifo model: read decided at negedge, performed at the edge
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         fq.delete();
         pend_q.delete();
      end else begin
         if (rd_take) fifo_dout <= fq.pop_front();
         while (pend_q.size() > 0) fq.push_back(pend_q.pop_front());
      end
      fifo_empty <= (fq.size() == 0);
   end

   // monitor
   always @(negedge clk) begin
      rd_take = fifo_rd_en && !fifo_empty;
      if (!reset) begin
         if (fifo_rd_en && fifo_empty) rd_viol++;
         if (fifo_rd_en) reads++;
         if (enable && !fifo_empty && first_n < 0) first_n = cyc;
         if (m_valid && first_v < 0) first_v = cyc;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", int'(m_data), -1);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               chk("m_data", int'(m_data), int'(e[7:0]));
               chk("m_last", int'(m_last), int'(e[8]));
            end
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push(input int start, input int n);
      for (int i = 0; i < n; i++) begin
         logic [7:0] v;
         v = 8'(start + i);
         pend_q.push_back(v);
         exp_q.push_back({(pushed % 8) == 7, v});
         pushed++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      pushed = 0;
      tick();
      @(negedge clk);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_m_last", int'(m_last), 0);
      chk("rst_rd_en", int'(fifo_rd_en), 0);
      chk("rst_word_count", int'(word_count), 0);
      tick();
      reset = 1'b0;
      pops = 0; reads = 0;
      first_n = -1; first_v = -1; first_pop = -1; last_pop = -1;
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while ((exp_q.size() != 0 || m_valid) && k < 300) begin
         tick();
         k++;
      end
      chk(nm, exp_q.size(), 0);
   endtask

   initial begin
      int p0, r0;
      reset = 1'b1; enable = 1'b0; m_ready = 1'b0;
      tick(); tick();
      do_reset();

      // 1: straight stream, latency and throughput
      enable = 1'b1; m_ready = 1'b1;
      push(0, 8);
      drain("t1_drained");
      chk("t1_pops", pops, 8);
      chk("t1_latency", first_v - first_n, 2);
      chk("t1_back_to_back", last_pop - first_pop, 7);

      // 2: backpressure, only two reads while stalled
      do_reset();
      enable = 1'b1; m_ready = 1'b0;
      push(0, 8);
      repeat (6) tick();
      @(negedge clk);
      chk("t2_reads", reads, 2);
      chk("t2_valid", int'(m_valid), 1);
      chk("t2_data", int'(m_data), 0);
      tick(); tick();
      @(negedge clk);
      chk("t2_data_stable", int'(m_data), 0);
      tick();
      m_ready = 1'b1;
      drain("t2_drained");
      chk("t2_pops", pops, 8);

      // 3: toggling ready over two bursts
      do_reset();
      enable = 1'b1;
      push(0, 16);
      for (int i = 0; i < 200 && (exp_q.size() != 0 || m_valid); i++) begin
         m_ready = i[0];
         tick();
      end
      m_ready = 1'b1;
      drain("t3_drained");
      chk("t3_pops", pops, 16);

      // 4: enable gating
      do_reset();
      enable = 1'b0; m_ready = 1'b1;
      push(0, 4);
      repeat (5) tick();
      @(negedge clk);
      chk("t4_no_reads", reads, 0);
      chk("t4_no_valid", int'(m_valid), 0);
      tick();
      enable = 1'b1;
      drain("t4_drained");
      chk("t4_pops", pops, 4);
      m_ready = 1'b0;
      push(4, 8);
      repeat (6) tick();
      enable = 1'b0; m_ready = 1'b1;
      p0 = pops; r0 = reads;
      repeat (6) tick();
      chk("t4_off_pops", pops - p0, 2);
      chk("t4_off_reads", reads - r0, 0);
      enable = 1'b1;
      drain("t4_resumed");

      // 5: reset mid-stream restarts burst framing
      do_reset();
      enable = 1'b1; m_ready = 1'b1;
      push(0, 8);
      for (int i = 0; i < 50 && pops < 3; i++) tick();
      do_reset();
      enable = 1'b1; m_ready = 1'b1;
      push(100, 8);
      drain("t5_drained");
      chk("t5_pops", pops, 8);

      // 6: word counter
      do_reset();
      enable = 1'b1; m_ready = 1'b1;
      push(50, 20);
      drain("t6_drained");
`ifdef FIFO_RD_CNT_EN
      chk("t6_word_count", int'(word_count), 20);
`else
      chk("t6_word_count", int'(word_count), 0);
`endif

      chk("rd_en_while_empty", rd_viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
